// File: rtl/demux_l2.sv
// demux_l2: receive-side lane splitter for the layer-2 single-lane link.
// Deals each valid input word alternately onto lane 0 and lane 1, with a
// pair-complete strobe and an odd-word error flag raised by flush.
module demux_l2 #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          HOLD_LAST = 1'b1
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic [WIDTH-1:0] Entrada,
  input  logic             validEntrada,
  input  logic             flush,
  output logic [WIDTH-1:0] Salida0,
  output logic             validSalida0,
  output logic [WIDTH-1:0] Salida1,
  output logic             validSalida1,
  output logic             par_valid,
  output logic             err_impar,
  output logic             lane_sel
);

  // Lane pointer: which lane receives the next valid word.
  typedef enum logic {
    ESPERA0 = 1'b0,
    ESPERA1 = 1'b1
  } state_e;

  state_e           state_q, state_d;
  state_e           ptr;
  logic [WIDTH-1:0] salida0_q, salida0_d;
  logic [WIDTH-1:0] salida1_q, salida1_d;
  logic [WIDTH-1:0] idle0, idle1;
  logic             valid0_q, valid0_d;
  logic             valid1_q, valid1_d;
  logic             par_q, par_d;
  logic             err_q, err_d;

  // State and output registers; reset drops any pending half-pair silently.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state_q   <= ESPERA0;
      salida0_q <= '0;
      salida1_q <= '0;
      valid0_q  <= 1'b0;
      valid1_q  <= 1'b0;
      par_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      salida0_q <= salida0_d;
      salida1_q <= salida1_d;
      valid0_q  <= valid0_d;
      valid1_q  <= valid1_d;
      par_q     <= par_d;
      err_q     <= err_d;
    end
  end

  // Next-state and lane routing; flush realigns the pointer before routing.
  always_comb begin
    ptr       = flush ? ESPERA0 : state_q;
    idle0     = HOLD_LAST ? salida0_q : '0;
    idle1     = HOLD_LAST ? salida1_q : '0;
    state_d   = ptr;
    salida0_d = idle0;
    salida1_d = idle1;
    valid0_d  = 1'b0;
    valid1_d  = 1'b0;
    par_d     = 1'b0;
    err_d     = flush && (state_q == ESPERA1);

    if (validEntrada) begin
      if (ptr == ESPERA0) begin
        salida0_d = Entrada;
        valid0_d  = 1'b1;
        state_d   = ESPERA1;
      end else begin
        // ptr can only be ESPERA1 when flush is low, so the pair is genuine.
        salida1_d = Entrada;
        valid1_d  = 1'b1;
        par_d     = 1'b1;
        state_d   = ESPERA0;
      end
    end
  end

  assign Salida0      = salida0_q;
  assign Salida1      = salida1_q;
  assign validSalida0 = valid0_q;
  assign validSalida1 = valid1_q;
  assign par_valid    = par_q;
  assign err_impar    = err_q;
  assign lane_sel     = (state_q == ESPERA1);

endmodule

// File: tb/tb_demux_l2.sv
// Scoreboard bench for demux_l2: one instance per HOLD_LAST setting, both
// driven by the same stimulus and checked against an independent lane model.
module tb_demux_l2;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] s0;
    logic [W-1:0] s1;
    logic         v0;
    logic         v1;
    logic         pv;
    logic         ei;
    logic         ls;
  } exp_t;

  logic         clk_2f = 1'b0;
  logic         reset;
  logic [W-1:0] Entrada;
  logic         validEntrada;
  logic         flush;

  logic [W-1:0] s0 [2];
  logic [W-1:0] s1 [2];
  logic         v0 [2];
  logic         v1 [2];
  logic         pv [2];
  logic         ei [2];
  logic         ls [2];

  int total = 0;
  int bad   = 0;

  exp_t exp_q [$];
  exp_t m_out [2];
  logic m_st  [2];

  always #5 clk_2f = ~clk_2f;

  demux_l2 #(.WIDTH(W), .HOLD_LAST(1'b1)) u_hold (
    .clk_2f(clk_2f), .reset(reset), .Entrada(Entrada),
    .validEntrada(validEntrada), .flush(flush),
    .Salida0(s0[0]), .validSalida0(v0[0]),
    .Salida1(s1[0]), .validSalida1(v1[0]),
    .par_valid(pv[0]), .err_impar(ei[0]), .lane_sel(ls[0])
  );

  demux_l2 #(.WIDTH(W), .HOLD_LAST(1'b0)) u_zero (
    .clk_2f(clk_2f), .reset(reset), .Entrada(Entrada),
    .validEntrada(validEntrada), .flush(flush),
    .Salida0(s0[1]), .validSalida0(v0[1]),
    .Salida1(s1[1]), .validSalida1(v1[1]),
    .par_valid(pv[1]), .err_impar(ei[1]), .lane_sel(ls[1])
  );

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int h = 0; h < 2; h++) begin
      m_st[h]  = 1'b0;
      m_out[h] = '0;
    end
  endtask

  // Expected behaviour of one edge, pushed for both HOLD_LAST settings.
  task automatic model_step(input logic v, input logic [W-1:0] d, input logic fl);
    for (int h = 0; h < 2; h++) begin
      exp_t e;
      logic hold;
      logic lane;
      hold = (h == 0);
      e    = m_out[h];
      lane = fl ? 1'b0 : m_st[h];
      e.ei = fl & m_st[h];
      e.pv = 1'b0;
      e.v0 = 1'b0;
      e.v1 = 1'b0;
      if (!hold) begin
        e.s0 = '0;
        e.s1 = '0;
      end
      if (v && !lane) begin
        e.s0    = d;
        e.v0    = 1'b1;
        m_st[h] = 1'b1;
      end else if (v && lane) begin
        e.s1    = d;
        e.v1    = 1'b1;
        e.pv    = 1'b1;
        m_st[h] = 1'b0;
      end else begin
        m_st[h] = lane;
      end
      e.ls     = m_st[h];
      m_out[h] = e;
      exp_q.push_back(e);
    end
  endtask

  task automatic compare_outputs();
    for (int h = 0; h < 2; h++) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        check($sformatf("sb_empty_h%0d", h), 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("Salida0_h%0d", h), 32'(s0[h]), 32'(e.s0));
        check($sformatf("Salida1_h%0d", h), 32'(s1[h]), 32'(e.s1));
        check($sformatf("valid0_h%0d", h), 32'(v0[h]), 32'(e.v0));
        check($sformatf("valid1_h%0d", h), 32'(v1[h]), 32'(e.v1));
        check($sformatf("par_valid_h%0d", h), 32'(pv[h]), 32'(e.pv));
        check($sformatf("err_impar_h%0d", h), 32'(ei[h]), 32'(e.ei));
        check($sformatf("lane_sel_h%0d", h), 32'(ls[h]), 32'(e.ls));
      end
      check($sformatf("valid_excl_h%0d", h), 32'(v0[h] & v1[h]), 32'd0);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int h = 0; h < 2; h++) begin
      check($sformatf("%s_s0_h%0d", tag, h), 32'(s0[h]), 32'd0);
      check($sformatf("%s_s1_h%0d", tag, h), 32'(s1[h]), 32'd0);
      check($sformatf("%s_v0_h%0d", tag, h), 32'(v0[h]), 32'd0);
      check($sformatf("%s_v1_h%0d", tag, h), 32'(v1[h]), 32'd0);
      check($sformatf("%s_pv_h%0d", tag, h), 32'(pv[h]), 32'd0);
      check($sformatf("%s_ei_h%0d", tag, h), 32'(ei[h]), 32'd0);
      check($sformatf("%s_ls_h%0d", tag, h), 32'(ls[h]), 32'd0);
    end
  endtask

  // Drive one cycle on the falling edge, check just after the rising edge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic fl);
    @(negedge clk_2f);
    validEntrada = v;
    Entrada      = d;
    flush        = fl;
    model_step(v, d, fl);
    @(posedge clk_2f);
    #1;
    compare_outputs();
  endtask

  initial begin
    reset        = 1'b1;
    Entrada      = '0;
    validEntrada = 1'b0;
    flush        = 1'b0;
    model_reset();

    // Reset held while valid traffic arrives: everything stays cleared.
    @(negedge clk_2f);
    validEntrada = 1'b1;
    Entrada      = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_2f);
      #1;
      check_zero("rst_hold");
    end
    @(negedge clk_2f);
    validEntrada = 1'b0;
    reset        = 1'b0;

    // Back-to-back pairs.
    step(1'b1, 8'hA1, 1'b0);
    check("tp_a1_lane0", 32'(s0[0]), 32'h0000_00A1);
    step(1'b1, 8'hB2, 1'b0);
    check("tp_b2_pair", 32'(pv[0]), 32'd1);
    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'hD4, 1'b0);

    // Gaps between the two halves of a pair.
    step(1'b1, 8'h11, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h22, 1'b0);

    // Flush with an unpaired lane-0 word pending.
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h66, 1'b1);
    check("tp_flush_err", 32'(ei[0]), 32'd1);
    step(1'b1, 8'h77, 1'b0);

    // Flush while idle, aligned and unaligned.
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h12, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);

    // Mixed random traffic.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 5) == 0));
    end

    // Asynchronous reset in the middle of a pair.
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'h9C, 1'b0);
    step(1'b1, 8'h9C, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_zero("rst_async");
    @(negedge clk_2f);
    reset        = 1'b0;
    validEntrada = 1'b0;
    flush        = 1'b0;
    model_reset();
    step(1'b1, 8'h3E, 1'b0);
    check("tp_3e_lane0", 32'(s0[0]), 32'h0000_003E);
    step(1'b0, 8'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
